if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the tinyMIPS pipeline, directly upstream of the decode stage. Owns the fetch PC, runs a request/acknowledge handshake with instruction memory, and presents the IF/ID pipeline register (`pc_o`, `inst_o`, `valid_o`) that drives decode's `pc_i`/`inst_i`. Honours a downstream stall and a redirect/flush, and buffers one instruction that returns while decode is stalled.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; low two bits must be zero.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-high. Despite the name, 1 = reset asserted.
- `stall_i`  in  1  decode or later stages hold; the IF/ID register must not advance.
- `flush_i`  in  1  redirect; takes priority over `stall_i`.
- `new_pc_i`  in  32  redirect target, sampled when `flush_i`=1; bits [1:0] forced to 0.
- `imem_req_o`  out  1  fetch request.
- `imem_addr_o`  out  32  fetch address; always word aligned.
- `imem_ack_i`  in  1  data valid on `imem_rdata_i`; may arrive in the same cycle as the request or later.
- `imem_rdata_i`  in  32  instruction word.
- `pc_o`  out  32  IF/ID register: PC of `inst_o`.
- `inst_o`  out  32  IF/ID register: instruction word; 0 (NOP) when `valid_o`=0.
- `valid_o`  out  1  IF/ID register holds a real instruction.
- `stall_cnt_o`  out  32  stall-cycle counter; present only with `IF_STALL_CNT_EN`.

## Operation
- Internal state: `fetch_pc` (32b), one-entry buffer (pc + inst), FSM with states IDLE, REQ, HOLD, DROP.
- Reset values: `fetch_pc`=`RESET_PC`, FSM=IDLE, `imem_req_o`=0, `imem_addr_o`=`RESET_PC`, `pc_o`=0, `inst_o`=0, `valid_o`=0, buffer empty, `stall_cnt_o`=0.
- `imem_addr_o`=`fetch_pc` in IDLE/REQ/HOLD. In DROP it is the abandoned address.
- IDLE: `imem_req_o`=0. Moves to REQ on the next edge.
- REQ: `imem_req_o`=1.
  - ack with `stall_i`=0: IF/ID loads {`fetch_pc`, rdata}, sets `valid_o`=1, `fetch_pc`+=4, FSM stays in REQ.
  - ack with `stall_i`=1: buffer captures {`fetch_pc`, rdata}, `fetch_pc`+=4, FSM moves to HOLD. IF/ID holds.
  - no ack with `stall_i`=0: IF/ID loads a bubble (`valid_o`=0, `inst_o`=0, `pc_o`=0).
  - no ack with `stall_i`=1: IF/ID holds.
- HOLD: `imem_req_o`=0. IF/ID holds while `stall_i`=1. When `stall_i`=0, IF/ID loads the buffer with `valid_o`=1, the buffer empties, and FSM moves to REQ.
- Flush (any state, overrides stall):
  - IF/ID cleared to a bubble; buffer emptied; `fetch_pc`={`new_pc_i`[31:2],2'b00}.
  - REQ without same-cycle ack: FSM moves to DROP.
  - REQ with same-cycle ack, or IDLE/HOLD: the returned data is discarded and FSM moves to REQ.
  - Flush while in DROP: updates `fetch_pc`, FSM stays in DROP.
- DROP: `imem_req_o`=1 and `imem_addr_o` holds the old address. The ack data is discarded, then FSM moves to REQ at the new `fetch_pc`. IF/ID shows bubbles (or holds under `stall_i`).
- Handshake rule: once `imem_req_o`=1, `imem_addr_o` and `imem_req_o` stay stable until the ack cycle. `imem_ack_i` is ignored when `imem_req_o`=0.
- Arithmetic: `fetch_pc`+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset release at edge N: IDLE during cycle N; request for `RESET_PC` visible in cycle N+1.
- Zero-wait memory (ack in the request cycle): the instruction appears on `inst_o` one cycle after the request. Throughput is 1 instruction/cycle with addresses PC, PC+4, … on consecutive cycles.
- Memory with k wait cycles: k bubbles per instruction.
- Flush at edge F: bubble in IF/ID from F. If no request is outstanding, the request for `new_pc_i` goes out in cycle F+1; otherwise it goes out the cycle after the outstanding ack.
- Async reset mid-handshake: all state returns to reset values immediately; the outstanding ack is not expected afterwards.

## Configuration
- `IF_STALL_CNT_EN` defined: `stall_cnt_o` increments by 1 (wrapping) on every edge where `stall_i`=1 and `rst_n`=0. Cleared only by reset.
- `IF_STALL_CNT_EN` undefined: the port and counter are absent.

## Test plan
- Reset, zero-wait memory, `RESET_PC`=0 → addresses 0,4,8,… on consecutive cycles; `inst_o` shows the rdata one cycle later with `valid_o`=1.
- Ack with 2 wait cycles for addr 0x10 → addr 0x10 stable for 3 cycles; two bubbles (`inst_o`=0, `valid_o`=0); then `pc_o`=0x10.
- Ack for 0x20 (data 0x3421_0001) while `stall_i`=1 for 3 cycles → IF/ID unchanged for 3 cycles, `imem_req_o`=0. The cycle after release: `pc_o`=0x20, `inst_o`=0x3421_0001.
- Flush to 0x103 while a request for 0x40 is pending → `imem_addr_o` stays 0x40 until ack; the 0x40 data never reaches `inst_o`; the next request is 0x100.
- Flush and stall asserted together with a valid instruction in IF/ID → IF/ID becomes a bubble; the next fetch is `new_pc_i`.
- `fetch_pc`=0xFFFF_FFFC with ack → next address 0x0. With `IF_STALL_CNT_EN`, 5 stall cycles → `stall_cnt_o`=5.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: tinyMIPS fetch stage with imem handshake, IF/ID register and one-entry stall buffer.
// Optional stall-cycle counter on stall_cnt_o when IF_STALL_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o
`ifdef IF_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;
  state_t      state, nxt_state;
  logic [31:0] fetch_pc, nxt_pc, buf_pc, buf_inst;
  logic        buf_vld, ack;
  // req is only ever high in REQ/DROP, so this also ignores stray acks
  assign ack = imem_ack_i & imem_req_o;
  always_comb begin
    nxt_state = state;
    nxt_pc    = fetch_pc;
    if (flush_i) begin
      nxt_pc    = {new_pc_i[31:2], 2'b00};
      nxt_state = ((state == REQ || state == DROP) && !ack) ? DROP : REQ;
    end else begin
      case (state)
        IDLE: nxt_state = REQ;
        REQ: begin
          nxt_pc    = ack ? fetch_pc + 32'd4 : fetch_pc;
          nxt_state = (ack && stall_i) ? HOLD : REQ;
        end
        HOLD: nxt_state = stall_i ? HOLD : REQ;
        DROP: nxt_state = ack ? REQ : DROP;
        default: nxt_state = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      imem_req_o  <= 1'b0;
      imem_addr_o <= RESET_PC;
      pc_o        <= '0;
      inst_o      <= '0;
      valid_o     <= 1'b0;
      buf_pc      <= '0;
      buf_inst    <= '0;
      buf_vld     <= 1'b0;
    end else begin
      state       <= nxt_state;
      fetch_pc    <= nxt_pc;
      imem_req_o  <= (nxt_state == REQ) || (nxt_state == DROP);
      // an abandoned request keeps its address until its ack arrives
      imem_addr_o <= (nxt_state == DROP) ? imem_addr_o : nxt_pc;
      if (flush_i) begin
        pc_o    <= '0;
        inst_o  <= '0;
        valid_o <= 1'b0;
        buf_vld <= 1'b0;
      end else if (state == REQ && ack && !stall_i) begin
        pc_o    <= fetch_pc;
        inst_o  <= imem_rdata_i;
        valid_o <= 1'b1;
      end else if (state == REQ && ack) begin
        buf_pc   <= fetch_pc;
        buf_inst <= imem_rdata_i;
        buf_vld  <= 1'b1;
      end else if (state == HOLD && !stall_i) begin
        pc_o    <= buf_pc;
        inst_o  <= buf_inst;
        valid_o <= buf_vld;
        buf_vld <= 1'b0;
      end else if (!stall_i) begin
        pc_o    <= '0;
        inst_o  <= '0;
        valid_o <= 1'b0;
      end
    end
  end
`ifdef IF_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) stall_cnt_o <= '0;
    else if (stall_i) stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif
endmodule
